serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes a − b − borrow-in over WIDTH cycles, one bit per clock, LSB first. It loads two parallel operands on a start request and drives the existing single-bit `full_subtractor` cell from shift registers. A registered borrow carries from one bit to the next. When the last bit is done, it presents a parallel difference and final borrow with a one-cycle done pulse. It is the sequencing stage directly upstream of `full_subtractor` and trades area for latency in the Tiny Tapeout tile.

---
 rtl/tt_pkg.sv | 11 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared constants for the serial arithmetic blocks in the tile.
// Other bit-serial units reuse this state encoding.
package tt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } serial_state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - borrow_in, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_in_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i ^ borrow_in_i;
    assign borrow_o = (~a_i & b_i) | (~a_i & borrow_in_i) | (b_i & borrow_in_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - borrow_in over WIDTH cycles, LSB first,
// with a parallel result and a one-cycle done pulse on completion.
module serial_subtractor
    import tt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    serial_state_e    state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic fs_diff;
    logic fs_borrow;

    full_subtractor u_full_subtractor (
        .a_i         (a_sh_q[0]),
        .b_i         (b_sh_q[0]),
        .borrow_in_i (bor_q),
        .diff_o      (fs_diff),
        .borrow_o    (fs_borrow)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    bor_d   = borrow_in_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {fs_diff, res_sh_q[WIDTH-1:1]};
                bor_d    = fs_borrow;
                cnt_d    = cnt_q + 1'b1;
                // The last bit is folded in here so diff_o never shows a partial result.
                if (cnt_q == LastCnt) begin
                    cnt_d    = '0;
                    diff_d   = {fs_diff, res_sh_q[WIDTH-1:1]};
                    borrow_d = fs_borrow;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            bor_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            bor_q    <= bor_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2, against an
// arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       bin2 = 1'b0;
    logic       busy2, done2, borrow2;
    logic [1:0] diff2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start8),
        .a_i         (a8),
        .b_i         (b8),
        .borrow_in_i (bin8),
        .busy_o      (busy8),
        .done_o      (done8),
        .diff_o      (diff8),
        .borrow_o    (borrow8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start2),
        .a_i         (a2),
        .b_i         (b2),
        .borrow_in_i (bin2),
        .busy_o      (busy2),
        .done_o      (done2),
        .diff_o      (diff2),
        .borrow_o    (borrow2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned arithmetic on integers.
    function automatic int ref_diff(input int a, input int b, input int bin, input int w);
        int m;
        m = 1 << w;
        return ((a - b - bin) % m + m) % m;
    endfunction

    function automatic int ref_borrow(input int a, input int b, input int bin);
        return (a < b + bin) ? 1 : 0;
    endfunction

    // Runs one WIDTH=8 operation from IDLE and leaves the DUT back in IDLE.
    task automatic op8(input int a, input int b, input int bin, input string tag);
        int lat;
        int busy_n;
        a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin); start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!done8 && lat < 30) begin
            if (busy8) busy_n++;
            tick();
            lat++;
        end
        if (busy8) busy_n++;
        check_eq({tag, " latency"}, lat, 8);
        check_eq({tag, " diff"}, diff8, ref_diff(a, b, bin, 8));
        check_eq({tag, " borrow"}, borrow8, ref_borrow(a, b, bin));
        check_eq({tag, " busy cycles"}, busy_n, 9);
        tick();
        check_eq({tag, " busy after"}, busy8, 0);
    endtask

    task automatic op2(input int a, input int b, input int bin);
        int lat;
        a2 = 2'(a); b2 = 2'(b); bin2 = 1'(bin); start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("w2 latency", lat, 2);
        check_eq("w2 diff", diff2, ref_diff(a, b, bin, 2));
        check_eq("w2 borrow", borrow2, ref_borrow(a, b, bin));
        tick();
    endtask

    initial begin
        int lat;
        int cnt;
        int d0, d1, d2;

        tick();
        tick();
        rst = 1'b0;
        check_eq("rst busy8", busy8, 0);
        check_eq("rst done8", done8, 0);
        check_eq("rst diff8", diff8, 0);
        check_eq("rst borrow8", borrow8, 0);
        check_eq("rst busy2", busy2, 0);
        check_eq("rst diff2", diff2, 0);

        op8(200, 55, 0, "normal");
        op8(55, 200, 0, "underflow");
        op8(0, 0, 1, "bin wrap");
        op8(255, 255, 0, "equal");

        // Requests during RUN and during DONE must be dropped.
        a8 = 8'd10; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'd99; b8 = 8'd1;
        tick(); tick(); tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 4;
        while (!done8 && lat < 30) begin
            tick();
            lat++;
        end
        check_eq("busy-start latency", lat, 8);
        check_eq("busy-start diff", diff8, 7);
        check_eq("busy-start borrow", borrow8, 0);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check_eq("done-start busy", busy8, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) cnt++;
        end
        check_eq("ignored start activity", cnt, 0);

        // Held start: completions every WIDTH+2 edges.
        a8 = 8'd5; b8 = 8'd2; bin8 = 1'b0; start8 = 1'b1;
        tick();
        d0 = -1; d1 = -1; d2 = -1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (done8) begin
                if (d0 < 0) d0 = k;
                else if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        start8 = 1'b0;
        check_eq("b2b first done", d0, 8);
        check_eq("b2b spacing 1", d1 - d0, 10);
        check_eq("b2b spacing 2", d2 - d1, 10);
        check_eq("b2b diff", diff8, 3);
        lat = 0;
        while (busy8 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("b2b drained", busy8, 0);

        // Abort mid-RUN with reset.
        a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort busy", busy8, 0);
        check_eq("abort done", done8, 0);
        check_eq("abort diff", diff8, 0);
        check_eq("abort borrow", borrow8, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) cnt++;
        end
        check_eq("abort no done", cnt, 0);
        op8(9, 4, 0, "after abort");

        for (int i = 0; i < 1000; i++) begin
            op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), "rand8");
        end

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    op2(a, b, bin);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
